// File: rtl/seg7_capture_pkg.sv
// Shared segment-bus definitions: bit positions and the hex glyph table used by
// both the encoder side and this capture side.
package seg7_capture_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned SEG_DP = 7;
  localparam int unsigned NGLYPH = 16;

  // Glyph for hex value i is SEG_PAT[i]; bit 0 = segment a .. bit 6 = segment g.
  localparam logic [SEG_W-1:0] SEG_PAT [NGLYPH] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2
  } cap_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Strict inverse of the 7-segment glyph table: any pattern outside the table
// (other than all-off, which means blank) is flagged as not ok.
module seg7_decode
  import seg7_capture_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       nibble,
  output logic             is_blank,
  output logic             ok
);

  always_comb begin
    nibble   = 4'h0;
    is_blank = (pattern == '0);
    ok       = is_blank;
    for (int i = 0; i < int'(NGLYPH); i++) begin
      if (pattern == SEG_PAT[i]) begin
        nibble = 4'(i);
        ok     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// Capture side of a multiplexed 7-segment bus: rebuilds per-digit values and
// publishes them once the same complete frame has been seen repeatedly.
module seg7_capture
  import seg7_capture_pkg::*;
#(
  parameter int unsigned NDIGITS       = 2,
  parameter int unsigned SETTLE        = 2,
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NDIGITS-1:0]     catodes,
  input  logic [7:0]             segments,
  output logic [4*NDIGITS-1:0]   bcd_bus,
  output logic [NDIGITS-1:0]     points,
  output logic [NDIGITS-1:0]     blank,
  output logic                   valid,
  output logic                   err
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned SW = $clog2(STABLE_FRAMES + 1);
  localparam int unsigned BW = 4 * NDIGITS;
  localparam int unsigned FW = BW + 2 * NDIGITS;

  logic [NDIGITS-1:0] cat_s1, cat_s2, cat_q;
  logic [7:0]         seg_s1, seg_s2;

  cap_state_t         state, state_nx;
  logic [CW-1:0]      cnt, cnt_nx;

  logic [BW-1:0]      fr_bcd, fr_bcd_nx;
  logic [NDIGITS-1:0] fr_dp, fr_dp_nx;
  logic [NDIGITS-1:0] fr_blank, fr_blank_nx;
  logic [FW-1:0]      prev, prev_nx;
  logic [NDIGITS-1:0] seen, seen_nx;
  logic [SW-1:0]      stable, stable_nx;
  logic               err_nx, pub_nx;

  logic [NDIGITS-1:0] low;
  logic               none_low, one_low, changed;
  logic [3:0]         dec_nibble;
  logic               dec_blank, dec_ok;

  // Two-flop synchronizer on the pins; idle bus is all catodes high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cat_s1 <= '1;
      cat_s2 <= '1;
      cat_q  <= '1;
      seg_s1 <= '0;
      seg_s2 <= '0;
    end else begin
      cat_s1 <= catodes;
      cat_s2 <= cat_s1;
      cat_q  <= cat_s2;
      seg_s1 <= segments;
      seg_s2 <= seg_s1;
    end
  end

  assign changed  = (cat_s2 != cat_q);
  assign low      = ~cat_s2;
  assign none_low = (low == '0);
  assign one_low  = !none_low && ((low & (low - NDIGITS'(1))) == '0);

  seg7_decode u_decode (
    .pattern  (seg_s2[SEG_W-1:0]),
    .nibble   (dec_nibble),
    .is_blank (dec_blank),
    .ok       (dec_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // A change landing on the sample cycle still has to be settled, so SAMPLE
  // falls through to SETTLE in that case instead of losing the edge in WAIT.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_WAIT: begin
        if (changed) begin
          state_nx = S_SETTLE;
          cnt_nx   = '0;
        end
      end
      S_SETTLE: begin
        if (changed) begin
          cnt_nx = '0;
        end else if (cnt == CW'(SETTLE - 1)) begin
          state_nx = S_SAMPLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_SAMPLE: begin
        state_nx = changed ? S_SETTLE : S_WAIT;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = S_WAIT;
        cnt_nx   = '0;
      end
    endcase
  end

  // Frame assembly, stability tracking and publish decision
  always_comb begin
    fr_bcd_nx   = fr_bcd;
    fr_dp_nx    = fr_dp;
    fr_blank_nx = fr_blank;
    prev_nx     = prev;
    seen_nx     = seen;
    stable_nx   = stable;
    err_nx      = 1'b0;
    pub_nx      = 1'b0;
    if (state == S_SAMPLE && !none_low) begin
      if (!one_low || !dec_ok) begin
        err_nx    = 1'b1;
        seen_nx   = '0;
        stable_nx = '0;
      end else begin
        for (int i = 0; i < int'(NDIGITS); i++) begin
          if (low[i]) begin
            fr_bcd_nx[4*i +: 4] = dec_nibble;
            fr_dp_nx[i]         = seg_s2[SEG_DP];
            fr_blank_nx[i]      = dec_blank;
            seen_nx[i]          = 1'b1;
          end
        end
        if (seen_nx == '1) begin
          if ({fr_bcd_nx, fr_dp_nx, fr_blank_nx} == prev) begin
            stable_nx = (stable >= SW'(STABLE_FRAMES)) ? stable : stable + SW'(1);
          end else begin
            stable_nx = SW'(1);
          end
          prev_nx = {fr_bcd_nx, fr_dp_nx, fr_blank_nx};
          seen_nx = '0;
          pub_nx  = (stable_nx >= SW'(STABLE_FRAMES)) &&
                    ({fr_bcd_nx, fr_dp_nx, fr_blank_nx} != {bcd_bus, points, blank});
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fr_bcd   <= '0;
      fr_dp    <= '0;
      fr_blank <= '1;
      prev     <= '0;
      seen     <= '0;
      stable   <= '0;
      bcd_bus  <= '0;
      points   <= '0;
      blank    <= '1;
      valid    <= 1'b0;
      err      <= 1'b0;
    end else begin
      fr_bcd   <= fr_bcd_nx;
      fr_dp    <= fr_dp_nx;
      fr_blank <= fr_blank_nx;
      prev     <= prev_nx;
      seen     <= seen_nx;
      stable   <= stable_nx;
      valid    <= pub_nx;
      err      <= err_nx;
      if (pub_nx) begin
        bcd_bus <= fr_bcd_nx;
        points  <= fr_dp_nx;
        blank   <= fr_blank_nx;
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: drives strobe sequences and checks the
// published digit set plus valid/err pulse counts.
module tb_seg7_capture;

  logic       clk;
  logic       rst;
  logic [1:0] catodes;
  logic [7:0] segments;
  logic [7:0] bcd_bus;
  logic [1:0] points;
  logic [1:0] blank;
  logic       valid;
  logic       err;

  int total = 0;
  int bad   = 0;
  int vcnt  = 0;
  int ecnt  = 0;
  int wide  = 0;
  int chg_bad = 0;
  int v0, e0;
  logic        err_d = 1'b0;
  logic [11:0] last_out = '0;

  seg7_capture #(.NDIGITS(2), .SETTLE(2), .STABLE_FRAMES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .catodes  (catodes),
    .segments (segments),
    .bcd_bus  (bcd_bus),
    .points   (points),
    .blank    (blank),
    .valid    (valid),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters and output-change monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) vcnt++;
      if (err) ecnt++;
      if (err && err_d) wide++;
      if (err && valid) wide++;
      if ({bcd_bus, points, blank} != last_out && !valid) chg_bad++;
    end
    err_d    = err;
    last_out = {bcd_bus, points, blank};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [1:0] c, input logic [7:0] s, input int n);
    catodes  = c;
    segments = s;
    repeat (n) @(posedge clk);
  endtask

  task automatic settle_out();
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    catodes = 2'b11;
    segments = 8'h00;
    repeat (3) @(posedge clk);
    rst = 1'b0;

    // 1: idle bus after reset
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("idle_bcd", 32'(bcd_bus), 32'h00);
    chk("idle_blank", 32'(blank), 32'h3);
    chk("idle_points", 32'(points), 32'h0);
    chk("idle_valid", 32'(vcnt), 32'd0);
    chk("idle_err", 32'(ecnt), 32'd0);

    // 2: digit1=3, digit0=7 with dp, three frames
    v0 = vcnt;
    repeat (3) begin
      strobe(2'b01, 8'h4F, 8);
      strobe(2'b10, 8'h87, 8);
    end
    settle_out();
    chk("f37_valid_cnt", 32'(vcnt - v0), 32'd1);
    chk("f37_bcd", 32'(bcd_bus), 32'h37);
    chk("f37_points", 32'(points), 32'h1);
    chk("f37_blank", 32'(blank), 32'h0);

    // 3: digit1 blanked
    v0 = vcnt;
    repeat (3) begin
      strobe(2'b01, 8'h00, 8);
      strobe(2'b10, 8'h87, 8);
    end
    settle_out();
    chk("blank_valid_cnt", 32'(vcnt - v0), 32'd1);
    chk("blank_blank", 32'(blank), 32'h2);
    chk("blank_bcd", 32'(bcd_bus), 32'h07);
    chk("blank_points", 32'(points), 32'h1);

    // 4: two digits strobed together, then unchanged clean frames
    v0 = vcnt;
    e0 = ecnt;
    strobe(2'b00, 8'h4F, 8);
    repeat (2) begin
      strobe(2'b01, 8'h00, 8);
      strobe(2'b10, 8'h87, 8);
    end
    settle_out();
    chk("multi_err_cnt", 32'(ecnt - e0), 32'd1);
    chk("multi_valid_cnt", 32'(vcnt - v0), 32'd0);
    chk("multi_bcd", 32'(bcd_bus), 32'h07);
    chk("multi_blank", 32'(blank), 32'h2);

    // 5: illegal glyph, then digit1 only ever shown as 1-cycle glitches
    v0 = vcnt;
    e0 = ecnt;
    strobe(2'b11, 8'h00, 8);
    strobe(2'b10, 8'h49, 8);
    repeat (3) begin
      strobe(2'b10, 8'h87, 8);
      strobe(2'b11, 8'h00, 8);
      strobe(2'b01, 8'h06, 1);
      strobe(2'b11, 8'h00, 8);
    end
    settle_out();
    chk("glitch_err_cnt", 32'(ecnt - e0), 32'd1);
    chk("glitch_valid_cnt", 32'(vcnt - v0), 32'd0);
    chk("glitch_bcd", 32'(bcd_bus), 32'h07);
    chk("glitch_points", 32'(points), 32'h1);

    // 6: reset in the middle of a new frame
    strobe(2'b10, 8'h7D, 8);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_bcd", 32'(bcd_bus), 32'h00);
    chk("rst_blank", 32'(blank), 32'h3);
    chk("rst_points", 32'(points), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    catodes = 2'b11;
    segments = 8'h00;
    repeat (3) @(posedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    v0 = vcnt;
    repeat (2) begin
      strobe(2'b01, 8'h66, 8);
      strobe(2'b10, 8'h7D, 8);
    end
    settle_out();
    chk("post_rst_valid_cnt", 32'(vcnt - v0), 32'd1);
    chk("post_rst_bcd", 32'(bcd_bus), 32'h46);
    chk("post_rst_blank", 32'(blank), 32'h0);
    chk("post_rst_points", 32'(points), 32'h0);

    chk("pulse_shape", 32'(wide), 32'd0);
    chk("silent_change", 32'(chg_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
